// File: rtl/tick_gen_multi_if.sv
// ----------------------------------------------------------------------------
// tick_gen_multi_if
//   Control/status bundle for the multi-channel clock-enable generator.
//   The master side (controller) drives enables, sync and divisor writes;
//   the slave side (tick_gen_multi) returns ticks, square waves and
//   pending-update flags.
//
//   en_i        [NUM_CH]  per-channel run enable
//   sync_i      [1]       restart all channel counters together
//   wr_en_i     [1]       divisor write strobe
//   wr_ch_i     [CH_W]    channel addressed by the write
//   wr_div_i    [DIV_W]   new divisor value
//   tick_o      [NUM_CH]  one-cycle pulse per divisor period
//   clk_o       [NUM_CH]  square-wave level per channel
//   upd_pend_o  [NUM_CH]  shadow divisor written, not yet active
// ----------------------------------------------------------------------------
interface tick_gen_multi_if #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 17
);
    // Channel address is at least one bit wide even for a single channel.
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] en_i;
    logic              sync_i;
    logic              wr_en_i;
    logic [CH_W-1:0]   wr_ch_i;
    logic [DIV_W-1:0]  wr_div_i;
    logic [NUM_CH-1:0] tick_o;
    logic [NUM_CH-1:0] clk_o;
    logic [NUM_CH-1:0] upd_pend_o;

    modport master (
        output en_i, sync_i, wr_en_i, wr_ch_i, wr_div_i,
        input  tick_o, clk_o, upd_pend_o
    );

    modport slave (
        input  en_i, sync_i, wr_en_i, wr_ch_i, wr_div_i,
        output tick_o, clk_o, upd_pend_o
    );
endinterface

// File: rtl/tick_gen_multi.sv
// ----------------------------------------------------------------------------
// tick_gen_multi
//   Multi-channel clock-enable generator. Each channel divides master_clk by a
//   runtime-programmable divisor and produces a registered one-cycle tick and
//   a registered square-wave level. Divisors are double-buffered (shadow ->
//   active at the period wrap) so a rate change never creates a runt period.
//   sync_i realigns every channel and commits all pending divisors at once.
//
//   master_clk  in   system clock
//   reset       in   synchronous, active-high reset
//   bus         slave modport of tick_gen_multi_if (enables, sync, divisor
//               writes in; tick_o, clk_o, upd_pend_o out)
// ----------------------------------------------------------------------------
module tick_gen_multi #(
    parameter int                      NUM_CH   = 2,
    parameter int                      DIV_W    = 17,
    parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = {17'd5208, 17'd83333}
) (
    input  logic            master_clk,
    input  logic            reset,
    tick_gen_multi_if.slave bus
);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0]  active_div [NUM_CH];
    logic [DIV_W-1:0]  shadow_div [NUM_CH];
    logic [DIV_W-1:0]  cnt        [NUM_CH];
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] clk_q;
    logic [NUM_CH-1:0] pend_q;

    logic [NUM_CH-1:0] idle;    // disabled or divisor 0: counter parked at 0
    logic [NUM_CH-1:0] wrap;    // last count of the period, cnt == D-1
    logic [NUM_CH-1:0] wr_sel;  // divisor write addressed to this channel

    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block can leave it unassigned and infer a latch.
        idle   = '0;
        wrap   = '0;
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idle[i]   = !bus.en_i[i] || (active_div[i] == '0);
            wrap[i]   = bus.en_i[i] && (active_div[i] != '0) &&
                        (cnt[i] == active_div[i] - ONE);
            // Out-of-range channel numbers never match any i, so they drop.
            wr_sel[i] = bus.wr_en_i && (int'(bus.wr_ch_i) == i);
        end
    end

    always_ff @(posedge master_clk) begin
        if (reset) begin
            // NOTE: the divisor arrays are reset explicitly; they are a few
            // flops per channel and must hold DIV_INIT straight out of reset.
            for (int i = 0; i < NUM_CH; i++) begin
                active_div[i] <= DIV_INIT[i*DIV_W +: DIV_W];
                shadow_div[i] <= DIV_INIT[i*DIV_W +: DIV_W];
                cnt[i]        <= '0;
            end
            tick_q <= '0;
            clk_q  <= '0;
            pend_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // Level follows the previous count; idle forces it low and
                // D=1 gives D>>1 == 0, so it is never high.
                clk_q[i] <= !idle[i] && (cnt[i] < (active_div[i] >> 1));

                if (bus.sync_i) begin
                    // Realign: restart the count, suppress this cycle's tick,
                    // commit whatever is in the shadow. A write now is lost.
                    cnt[i]        <= '0;
                    tick_q[i]     <= 1'b0;
                    active_div[i] <= shadow_div[i];
                    pend_q[i]     <= 1'b0;
                end else begin
                    if (idle[i]) begin
                        cnt[i]    <= '0;
                        tick_q[i] <= 1'b0;
                    end else begin
                        cnt[i]    <= wrap[i] ? '0 : cnt[i] + ONE;
                        tick_q[i] <= wrap[i];
                    end

                    // Commit uses the shadow value from before this edge, so
                    // a write landing on the wrap edge waits for the next one.
                    if (pend_q[i] && (wrap[i] || idle[i])) begin
                        active_div[i] <= shadow_div[i];
                        pend_q[i]     <= 1'b0;
                    end

                    // NOTE: non-blocking assignments throughout; this later
                    // assignment to pend_q deliberately overrides the commit
                    // clear above when a write and a wrap share an edge.
                    if (wr_sel[i]) begin
                        shadow_div[i] <= bus.wr_div_i;
                        pend_q[i]     <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.tick_o     = tick_q;
    assign bus.clk_o      = clk_q;
    assign bus.upd_pend_o = pend_q;

endmodule

// File: tb/tb_tick_gen_multi.sv
// ----------------------------------------------------------------------------
// tb_tick_gen_multi
//   Self-checking bench for tick_gen_multi with its default configuration
//   (ch0 = 83333, ch1 = 5208). Expected tick cycles are pushed to per-channel
//   queues when stimulus is driven; observed tick cycles are collected from
//   the DUT and popped against them.
// ----------------------------------------------------------------------------
module tb_tick_gen_multi;
    localparam int NUM_CH = 2;
    localparam int DIV_W  = 17;
    localparam int D0     = 83333;
    localparam int D1     = 5208;

    logic master_clk = 1'b0;
    logic reset      = 1'b1;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int e0;
    int s_edge;

    int exp0[$];
    int exp1[$];
    int obs0[$];
    int obs1[$];

    tick_gen_multi_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus();

    tick_gen_multi #(
        .NUM_CH  (NUM_CH),
        .DIV_W   (DIV_W),
        .DIV_INIT({17'd5208, 17'd83333})
    ) dut (
        .master_clk(master_clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 master_clk = ~master_clk;
    always @(posedge master_clk) cyc <= cyc + 1;

    // Advance n edges, sampling 1 time unit after each edge and logging ticks.
    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge master_clk);
            #1;
            if (bus.tick_o[0]) obs0.push_back(cyc);
            if (bus.tick_o[1]) obs1.push_back(cyc);
        end
    endtask

    task automatic collect_until(input int target);
        collect(target - cyc);
    endtask

    task automatic test_reset;
        bus.en_i = 2'b11; bus.sync_i = 0; bus.wr_en_i = 0;
        bus.wr_ch_i = 0; bus.wr_div_i = '0;
        reset = 1'b1;
        collect(3);
        total++; if (bus.tick_o !== 2'b00) begin bad++; $display("FAIL rst_tick: got %b expected 00", bus.tick_o); end
        total++; if (bus.clk_o !== 2'b00) begin bad++; $display("FAIL rst_clk: got %b expected 00", bus.clk_o); end
        total++; if (bus.upd_pend_o !== 2'b00) begin bad++; $display("FAIL rst_pend: got %b expected 00", bus.upd_pend_o); end
        e0 = cyc;
        reset = 1'b0;
    endtask

    task automatic test_defaults;
        int e, o;
        obs0.delete(); obs1.delete();
        exp0.push_back(e0 + D0);
        for (int k = 1; k <= 16; k++) exp1.push_back(e0 + k * D1);
        collect_until(e0 + D0);
        while (exp0.size() > 0) begin
            e = exp0.pop_front(); total++;
            if (obs0.size() == 0) begin bad++; $display("FAIL def_tick0: got none expected cycle %0d", e); end
            else begin o = obs0.pop_front(); if (o !== e) begin bad++; $display("FAIL def_tick0: got cycle %0d expected %0d", o, e); end end
        end
        total++; if (obs0.size() != 0) begin bad++; $display("FAIL def_extra0: got %0d extra ticks expected 0", obs0.size()); end
        while (exp1.size() > 0) begin
            e = exp1.pop_front(); total++;
            if (obs1.size() == 0) begin bad++; $display("FAIL def_tick1: got none expected cycle %0d", e); end
            else begin o = obs1.pop_front(); if (o !== e) begin bad++; $display("FAIL def_tick1: got cycle %0d expected %0d", o, e); end end
        end
        total++; if (obs1.size() != 0) begin bad++; $display("FAIL def_extra1: got %0d extra ticks expected 0", obs1.size()); end
    endtask

    task automatic test_div_update;
        int e, o, t;
        logic want;
        obs1.delete();
        bus.wr_en_i = 1; bus.wr_ch_i = 1; bus.wr_div_i = 17'd4;
        collect(1);
        bus.wr_en_i = 0;
        total++; if (bus.upd_pend_o !== 2'b10) begin bad++; $display("FAIL upd_pend_set: got %b expected 10", bus.upd_pend_o); end
        t = e0 + 17 * D1;  // old 5208 period still completes
        exp1.push_back(t); exp1.push_back(t + 4); exp1.push_back(t + 8);
        collect_until(t - 1);
        total++; if (bus.upd_pend_o[1] !== 1'b1) begin bad++; $display("FAIL upd_pend_hold: got %b expected 1", bus.upd_pend_o[1]); end
        collect(1);
        total++; if (bus.upd_pend_o[1] !== 1'b0) begin bad++; $display("FAIL upd_pend_clr: got %b expected 0", bus.upd_pend_o[1]); end
        for (int k = 1; k <= 8; k++) begin
            collect(1);
            want = ((k % 4) == 1) || ((k % 4) == 2);
            total++; if (bus.clk_o[1] !== want) begin bad++; $display("FAIL upd_clk1 k=%0d: got %b expected %b", k, bus.clk_o[1], want); end
        end
        while (exp1.size() > 0) begin
            e = exp1.pop_front(); total++;
            if (obs1.size() == 0) begin bad++; $display("FAIL upd_tick1: got none expected cycle %0d", e); end
            else begin o = obs1.pop_front(); if (o !== e) begin bad++; $display("FAIL upd_tick1: got cycle %0d expected %0d", o, e); end end
        end
        total++; if (obs1.size() != 0) begin bad++; $display("FAIL upd_extra1: got %0d extra ticks expected 0", obs1.size()); end
    endtask

    task automatic test_div_one_zero;
        int e, o, a;
        // Park ch0 so the write commits on the next cycle.
        bus.en_i = 2'b10; bus.wr_en_i = 1; bus.wr_ch_i = 0; bus.wr_div_i = 17'd1;
        collect(1);
        total++; if (bus.upd_pend_o[0] !== 1'b1) begin bad++; $display("FAIL d1_pend: got %b expected 1", bus.upd_pend_o[0]); end
        bus.wr_en_i = 0;
        collect(1);
        total++; if (bus.upd_pend_o[0] !== 1'b0) begin bad++; $display("FAIL d1_commit: got %b expected 0", bus.upd_pend_o[0]); end
        bus.en_i = 2'b11;
        for (int k = 0; k < 6; k++) begin
            collect(1);
            total++; if ({bus.tick_o[0], bus.clk_o[0]} !== 2'b10) begin bad++; $display("FAIL d1_out k=%0d: got tick/clk %b%b expected 10", k, bus.tick_o[0], bus.clk_o[0]); end
        end
        bus.wr_en_i = 1; bus.wr_div_i = 17'd0;
        collect(1);
        bus.wr_en_i = 0;
        collect(2);
        for (int k = 0; k < 5; k++) begin
            total++; if ({bus.tick_o[0], bus.clk_o[0]} !== 2'b00) begin bad++; $display("FAIL d0_out k=%0d: got tick/clk %b%b expected 00", k, bus.tick_o[0], bus.clk_o[0]); end
            collect(1);
        end
        // From the idle (D=0) state the counter must start at 0: first tick 4 edges after the write.
        bus.wr_en_i = 1; bus.wr_div_i = 17'd3;
        collect(1);
        a = cyc;
        bus.wr_en_i = 0;
        total++; if (bus.upd_pend_o[0] !== 1'b1) begin bad++; $display("FAIL d3_pend: got %b expected 1", bus.upd_pend_o[0]); end
        obs0.delete();
        exp0.push_back(a + 4); exp0.push_back(a + 7); exp0.push_back(a + 10);
        collect_until(a + 10);
        while (exp0.size() > 0) begin
            e = exp0.pop_front(); total++;
            if (obs0.size() == 0) begin bad++; $display("FAIL d3_tick0: got none expected cycle %0d", e); end
            else begin o = obs0.pop_front(); if (o !== e) begin bad++; $display("FAIL d3_tick0: got cycle %0d expected %0d", o, e); end end
        end
        total++; if (obs0.size() != 0) begin bad++; $display("FAIL d3_extra0: got %0d extra ticks expected 0", obs0.size()); end
    endtask

    task automatic test_sync;
        int e, o, ee;
        bus.en_i = 2'b00; bus.wr_en_i = 1; bus.wr_ch_i = 0; bus.wr_div_i = 17'd10;
        collect(1);
        bus.wr_ch_i = 1;
        collect(1);
        bus.wr_en_i = 0;
        collect(1);
        obs0.delete(); obs1.delete();
        bus.en_i = 2'b01;
        collect(1);
        ee = cyc;
        collect(2);
        bus.en_i = 2'b11;
        collect(1);
        exp0.push_back(ee + 9);  exp0.push_back(ee + 19);
        exp1.push_back(ee + 12); exp1.push_back(ee + 22);
        collect_until(ee + 28);
        // Sync lands on ch0's wrap edge; a write in the same cycle is dropped.
        bus.sync_i = 1; bus.wr_en_i = 1; bus.wr_ch_i = 0; bus.wr_div_i = 17'd5;
        collect(1);
        s_edge = cyc;
        bus.sync_i = 0; bus.wr_en_i = 0;
        total++; if (bus.tick_o !== 2'b00) begin bad++; $display("FAIL sync_tick: got %b expected 00", bus.tick_o); end
        total++; if (bus.upd_pend_o !== 2'b00) begin bad++; $display("FAIL sync_pend: got %b expected 00", bus.upd_pend_o); end
        while (exp0.size() > 0) begin
            e = exp0.pop_front(); total++;
            if (obs0.size() == 0) begin bad++; $display("FAIL pre_tick0: got none expected cycle %0d", e); end
            else begin o = obs0.pop_front(); if (o !== e) begin bad++; $display("FAIL pre_tick0: got cycle %0d expected %0d", o, e); end end
        end
        while (exp1.size() > 0) begin
            e = exp1.pop_front(); total++;
            if (obs1.size() == 0) begin bad++; $display("FAIL pre_tick1: got none expected cycle %0d", e); end
            else begin o = obs1.pop_front(); if (o !== e) begin bad++; $display("FAIL pre_tick1: got cycle %0d expected %0d", o, e); end end
        end
        obs0.delete(); obs1.delete();
        exp0.push_back(s_edge + 10); exp0.push_back(s_edge + 20);
        exp1.push_back(s_edge + 10); exp1.push_back(s_edge + 20);
        collect_until(s_edge + 21);
        while (exp0.size() > 0) begin
            e = exp0.pop_front(); total++;
            if (obs0.size() == 0) begin bad++; $display("FAIL post_tick0: got none expected cycle %0d", e); end
            else begin o = obs0.pop_front(); if (o !== e) begin bad++; $display("FAIL post_tick0: got cycle %0d expected %0d", o, e); end end
        end
        total++; if (obs0.size() != 0) begin bad++; $display("FAIL post_extra0: got %0d extra ticks expected 0", obs0.size()); end
        while (exp1.size() > 0) begin
            e = exp1.pop_front(); total++;
            if (obs1.size() == 0) begin bad++; $display("FAIL post_tick1: got none expected cycle %0d", e); end
            else begin o = obs1.pop_front(); if (o !== e) begin bad++; $display("FAIL post_tick1: got cycle %0d expected %0d", o, e); end end
        end
        total++; if (obs1.size() != 0) begin bad++; $display("FAIL post_extra1: got %0d extra ticks expected 0", obs1.size()); end
    endtask

    task automatic test_wrap_write;
        int e, o;
        obs0.delete();
        exp0.push_back(s_edge + 30); exp0.push_back(s_edge + 36);
        exp0.push_back(s_edge + 42); exp0.push_back(s_edge + 45);
        exp0.push_back(s_edge + 48);
        bus.wr_en_i = 1; bus.wr_ch_i = 0; bus.wr_div_i = 17'd6;
        collect(1);
        bus.wr_en_i = 0;
        total++; if (bus.upd_pend_o[0] !== 1'b1) begin bad++; $display("FAIL ww_pend6: got %b expected 1", bus.upd_pend_o[0]); end
        collect_until(s_edge + 35);
        bus.wr_en_i = 1; bus.wr_div_i = 17'd3;
        collect(1);
        bus.wr_en_i = 0;
        total++; if (bus.upd_pend_o[0] !== 1'b1) begin bad++; $display("FAIL ww_pend3: got %b expected 1", bus.upd_pend_o[0]); end
        collect_until(s_edge + 42);
        total++; if (bus.upd_pend_o[0] !== 1'b0) begin bad++; $display("FAIL ww_commit3: got %b expected 0", bus.upd_pend_o[0]); end
        collect_until(s_edge + 48);
        while (exp0.size() > 0) begin
            e = exp0.pop_front(); total++;
            if (obs0.size() == 0) begin bad++; $display("FAIL ww_tick0: got none expected cycle %0d", e); end
            else begin o = obs0.pop_front(); if (o !== e) begin bad++; $display("FAIL ww_tick0: got cycle %0d expected %0d", o, e); end end
        end
        total++; if (obs0.size() != 0) begin bad++; $display("FAIL ww_extra0: got %0d extra ticks expected 0", obs0.size()); end
    endtask

    task automatic test_reset_mid;
        bus.wr_en_i = 1; bus.wr_ch_i = 1; bus.wr_div_i = 17'd7;
        collect(1);
        bus.wr_en_i = 0;
        total++; if (bus.upd_pend_o[1] !== 1'b1) begin bad++; $display("FAIL rm_pend: got %b expected 1", bus.upd_pend_o[1]); end
        collect(2);
        reset = 1'b1;
        collect(1);
        reset = 1'b0;
        total++; if (bus.tick_o !== 2'b00) begin bad++; $display("FAIL rm_tick: got %b expected 00", bus.tick_o); end
        total++; if (bus.clk_o !== 2'b00) begin bad++; $display("FAIL rm_clk: got %b expected 00", bus.clk_o); end
        total++; if (bus.upd_pend_o !== 2'b00) begin bad++; $display("FAIL rm_pend_clr: got %b expected 00", bus.upd_pend_o); end
        // DIV_INIT periods are far longer than this window; the discarded
        // divisor 7 (or a surviving ch0 divisor 3) would tick inside it.
        obs0.delete(); obs1.delete();
        collect(30);
        total++; if (obs0.size() != 0) begin bad++; $display("FAIL rm_ticks0: got %0d ticks expected 0", obs0.size()); end
        total++; if (obs1.size() != 0) begin bad++; $display("FAIL rm_ticks1: got %0d ticks expected 0", obs1.size()); end
        total++; if (bus.upd_pend_o !== 2'b00) begin bad++; $display("FAIL rm_pend_end: got %b expected 00", bus.upd_pend_o); end
    endtask

    initial begin
        bus.en_i = 2'b00; bus.sync_i = 0; bus.wr_en_i = 0;
        bus.wr_ch_i = 0; bus.wr_div_i = '0;
        test_reset;
        test_defaults;
        test_div_update;
        test_div_one_zero;
        test_sync;
        test_wrap_write;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
